lcd_cmd_sequencer: RTL and testbench

LCD_CMD_SEQUENCER -- requirements
Module: lcd_cmd_sequencer

---
 rtl/lcd_cmd_sequencer.sv | 128 ++++++++++++
 tb/tb_lcd_cmd_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_sequencer.sv
// rtl/lcd_cmd_sequencer.sv - table-driven LCD command sequencer feeding an SPI engine
// Optional LCD_SEQ_DELAY_EN enables the per-entry post-command delay field and DELAY state.
module lcd_cmd_sequencer #(
    parameter int                DATA_W    = 10,
    parameter int                ADDR_W    = 5,
    parameter int                DLY_W     = 16,
    parameter logic [DATA_W-1:0] IDLE_WORD = 10'h32F
) (
    input  logic                    CLK,
    input  logic                    RSTn,
    input  logic                    Start_Sig,
    input  logic                    Abort_Sig,
    input  logic [ADDR_W-1:0]       Seq_Len,
    output logic [ADDR_W-1:0]       Tbl_Addr,
    input  logic [DATA_W+DLY_W-1:0] Tbl_Data,
    output logic                    SPI_Start_Sig,
    output logic [DATA_W-1:0]       SPI_Data,
    input  logic                    SPI_Done_Sig,
    output logic                    Busy_Sig,
    output logic                    Done_Sig
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_SEND   = 3'd3;
    localparam logic [2:0] S_DELAY  = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    logic [2:0]        state;
    logic [ADDR_W-1:0] len_q;
    logic              last_entry;
    logic              go_delay;
    logic              advance;

`ifdef LCD_SEQ_DELAY_EN
    localparam logic [DLY_W-1:0] DLY_ONE = 1;
    logic [DLY_W-1:0] dly_cnt;

    assign go_delay = (dly_cnt != '0);
    assign advance  = (state == S_SEND && SPI_Done_Sig && !go_delay) ||
                      (state == S_DELAY && dly_cnt <= DLY_ONE);
`else
    // Delay bits of each table entry are deliberately dropped in this build.
    logic unused_dly;
    assign unused_dly = ^Tbl_Data[DATA_W+DLY_W-1:DATA_W];
    assign go_delay   = 1'b0;
    assign advance    = (state == S_SEND && SPI_Done_Sig);
`endif

    assign last_entry = (Tbl_Addr == len_q - ADDR_ONE);
    assign Busy_Sig   = (state != S_IDLE);
    assign Done_Sig   = (state == S_FINISH);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state         <= S_IDLE;
            len_q         <= '0;
            Tbl_Addr      <= '0;
            SPI_Start_Sig <= 1'b0;
            SPI_Data      <= IDLE_WORD;
`ifdef LCD_SEQ_DELAY_EN
            dly_cnt       <= '0;
`endif
        end else if (Abort_Sig && state != S_IDLE) begin
            // Abort outranks everything else, including a same-cycle SPI completion.
            state         <= S_IDLE;
            Tbl_Addr      <= '0;
            SPI_Start_Sig <= 1'b0;
            SPI_Data      <= IDLE_WORD;
`ifdef LCD_SEQ_DELAY_EN
            dly_cnt       <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start_Sig) begin
                        Tbl_Addr <= '0;
                        if (Seq_Len != '0) begin
                            len_q <= Seq_Len;
                            state <= S_FETCH;
                        end else begin
                            state <= S_FINISH;
                        end
                    end
                end
                S_FETCH: state <= S_LOAD;
                S_LOAD: begin
                    SPI_Data      <= Tbl_Data[DATA_W-1:0];
                    SPI_Start_Sig <= 1'b1;
                    state         <= S_SEND;
`ifdef LCD_SEQ_DELAY_EN
                    dly_cnt       <= Tbl_Data[DATA_W+DLY_W-1:DATA_W];
`endif
                end
                S_SEND: begin
                    if (SPI_Done_Sig) begin
                        SPI_Start_Sig <= 1'b0;
                        if (go_delay) state <= S_DELAY;
                    end
                end
`ifdef LCD_SEQ_DELAY_EN
                S_DELAY: begin
                    if (dly_cnt != '0) dly_cnt <= dly_cnt - DLY_ONE;
                end
`endif
                S_FINISH: begin
                    SPI_Data <= IDLE_WORD;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (advance) begin
                if (last_entry) begin
                    state    <= S_FINISH;
                    SPI_Data <= IDLE_WORD;
                end else begin
                    Tbl_Addr <= Tbl_Addr + ADDR_ONE;
                    state    <= S_FETCH;
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// tb/tb_lcd_cmd_sequencer.sv - directed bench for lcd_cmd_sequencer with ROM and SPI responder models
module tb_lcd_cmd_sequencer;

    localparam int DATA_W = 10;
    localparam int ADDR_W = 5;
    localparam int DLY_W  = 16;
`ifdef LCD_SEQ_DELAY_EN
    localparam int EXP_GAP = 102;
`else
    localparam int EXP_GAP = 2;
`endif

    logic                    CLK = 1'b0;
    logic                    RSTn;
    logic                    Start_Sig;
    logic                    Abort_Sig;
    logic [ADDR_W-1:0]       Seq_Len;
    logic [ADDR_W-1:0]       Tbl_Addr;
    logic [DATA_W+DLY_W-1:0] Tbl_Data;
    logic                    SPI_Start_Sig;
    logic [DATA_W-1:0]       SPI_Data;
    logic                    SPI_Done_Sig;
    logic                    Busy_Sig;
    logic                    Done_Sig;

    lcd_cmd_sequencer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DLY_W(DLY_W), .IDLE_WORD(10'h32F)
    ) dut (
        .CLK(CLK), .RSTn(RSTn), .Start_Sig(Start_Sig), .Abort_Sig(Abort_Sig),
        .Seq_Len(Seq_Len), .Tbl_Addr(Tbl_Addr), .Tbl_Data(Tbl_Data),
        .SPI_Start_Sig(SPI_Start_Sig), .SPI_Data(SPI_Data), .SPI_Done_Sig(SPI_Done_Sig),
        .Busy_Sig(Busy_Sig), .Done_Sig(Done_Sig)
    );

    always #5 CLK = ~CLK;

    logic [DATA_W+DLY_W-1:0] rom [32];
    always @(posedge CLK) Tbl_Data <= rom[Tbl_Addr];

    typedef struct {
        int seq_len;
        int lat;
        int exp_cycles;
        int exp_xfers;
        int exp_max_addr;
    } vec_t;
    vec_t vecs [5];

    int              pass_cnt = 0;
    int              total_cnt = 0;
    int              lat = 4;
    int              wcnt = 0;
    int              abort_entry = -1;
    int              unstable = 0;
    int              done_cnt = 0;
    int              rise_cnt = 0;
    int              max_addr = 0;
    logic            prev_start = 1'b0;
    logic [9:0]      req_word;
    logic [9:0]      xfer_log [$];
    logic [7:0]      init_bytes [11];

    // SPI engine: completes each request lat cycles after it rises.
    initial begin
        SPI_Done_Sig = 1'b0;
        forever begin
            @(negedge CLK);
            SPI_Done_Sig = 1'b0;
            if (SPI_Start_Sig) begin
                wcnt++;
                if (wcnt == 1) req_word = SPI_Data;
                if (wcnt >= lat) begin
                    SPI_Done_Sig = 1'b1;
                    wcnt = 0;
                    if (SPI_Data != req_word) unstable++;
                    if (xfer_log.size() == abort_entry) Abort_Sig = 1'b1;
                    xfer_log.push_back(SPI_Data);
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (Done_Sig) done_cnt++;
            if (SPI_Start_Sig && !prev_start) rise_cnt++;
            prev_start = SPI_Start_Sig;
            if (Busy_Sig && int'(Tbl_Addr) > max_addr) max_addr = int'(Tbl_Addr);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic clear_stats();
        xfer_log.delete();
        done_cnt = 0;
        rise_cnt = 0;
        max_addr = 0;
        unstable = 0;
    endtask

    task automatic pulse_start(input int n);
        @(negedge CLK);
        Seq_Len   = ADDR_W'(n);
        Start_Sig = 1'b1;
        @(negedge CLK);
        Start_Sig = 1'b0;
    endtask

    task automatic run_seq(input int n, output int cycles);
        @(negedge CLK);
        Seq_Len   = ADDR_W'(n);
        Start_Sig = 1'b1;
        cycles    = -1;
        for (int k = 1; k <= 5000; k++) begin
            @(posedge CLK);
            #1;
            Start_Sig = 1'b0;
            if (Done_Sig) begin
                cycles = k;
                break;
            end
        end
        repeat (3) @(negedge CLK);
    endtask

    task automatic wait_entry(input int a, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge CLK);
            if (int'(Tbl_Addr) == a && SPI_Start_Sig) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_done();
        for (int k = 0; k < 5000; k++) begin
            @(negedge CLK);
            if (done_cnt > 0) break;
        end
        repeat (4) @(negedge CLK);
    endtask

    initial begin
        int  cyc;
        int  bad;
        int  meas;
        bit  ok;

        init_bytes = '{8'hAF, 8'h40, 8'hA6, 8'hA0, 8'hC8, 8'hA4, 8'hA2, 8'h2F, 8'h24, 8'h81, 8'h24};
        for (int i = 0; i < 32; i++) rom[i] = {16'd0, 2'b01, 8'(i * 7 + 3)};
        for (int i = 0; i < 11; i++) rom[i] = {16'd0, 2'b00, init_bytes[i]};

        vecs[0] = '{seq_len: 11, lat: 4, exp_cycles: 67, exp_xfers: 11, exp_max_addr: 10};
        vecs[1] = '{seq_len: 0,  lat: 4, exp_cycles: 1,  exp_xfers: 0,  exp_max_addr: 0};
        vecs[2] = '{seq_len: 1,  lat: 1, exp_cycles: 4,  exp_xfers: 1,  exp_max_addr: 0};
        vecs[3] = '{seq_len: 3,  lat: 2, exp_cycles: 13, exp_xfers: 3,  exp_max_addr: 2};
        vecs[4] = '{seq_len: 31, lat: 1, exp_cycles: 94, exp_xfers: 31, exp_max_addr: 30};

        RSTn = 1'b0; Start_Sig = 1'b0; Abort_Sig = 1'b0; Seq_Len = '0;
        repeat (3) @(negedge CLK);
        check("reset_outputs", int'({Busy_Sig, Done_Sig, SPI_Start_Sig, Tbl_Addr, SPI_Data}), 'h32F);

        RSTn = 1'b1; Start_Sig = 1'b1; Seq_Len = 5'd1;
        @(posedge CLK);
        #1 Start_Sig = 1'b0;
        check("start_first_edge", int'(Busy_Sig), 1);
        for (int k = 0; k < 100; k++) begin
            @(negedge CLK);
            if (!Busy_Sig) break;
        end

        for (int i = 0; i < 5; i++) begin
            clear_stats();
            lat = vecs[i].lat;
            run_seq(vecs[i].seq_len, cyc);
            bad = 0;
            for (int j = 0; j < xfer_log.size(); j++)
                if (j < 32 && xfer_log[j] != rom[j][9:0]) bad++;
            check($sformatf("vec%0d_cycles", i), cyc, vecs[i].exp_cycles);
            check($sformatf("vec%0d_xfers", i), xfer_log.size(), vecs[i].exp_xfers);
            check($sformatf("vec%0d_order", i), bad, 0);
            check($sformatf("vec%0d_idle_word", i), int'(SPI_Data), 'h32F);
            check($sformatf("vec%0d_done_pulses", i), done_cnt, 1);
            check($sformatf("vec%0d_spi_starts", i), rise_cnt, vecs[i].exp_xfers);
            check($sformatf("vec%0d_max_addr", i), max_addr, vecs[i].exp_max_addr);
            check($sformatf("vec%0d_data_stable", i), unstable, 0);
        end

        // Abort coinciding with SPI completion of entry 3.
        clear_stats();
        lat = 4;
        abort_entry = 3;
        pulse_start(11);
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(posedge CLK);
            #1;
            if (Abort_Sig) begin
                ok = 1'b1;
                break;
            end
        end
        check("abort_seen", int'(ok), 1);
        check("abort_outputs", int'({Busy_Sig, Done_Sig, SPI_Start_Sig, Tbl_Addr, SPI_Data}), 'h32F);
        Abort_Sig = 1'b0;
        abort_entry = -1;
        repeat (6) @(negedge CLK);
        check("abort_no_done", done_cnt, 0);

        // Start pulse with a new length during entry 5 must be ignored.
        clear_stats();
        pulse_start(11);
        wait_entry(5, ok);
        check("ignore_reach_entry5", int'(ok), 1);
        Start_Sig = 1'b1;
        Seq_Len   = 5'd3;
        @(negedge CLK);
        Start_Sig = 1'b0;
        wait_done();
        check("ignore_done_once", done_cnt, 1);
        check("ignore_xfers", xfer_log.size(), 11);

        // Asynchronous reset in the middle of entry 2.
        clear_stats();
        pulse_start(11);
        wait_entry(2, ok);
        check("reset_reach_entry2", int'(ok), 1);
        #2 RSTn = 1'b0;
        #1 check("reset_mid_outputs", int'({Busy_Sig, Done_Sig, SPI_Start_Sig, Tbl_Addr, SPI_Data}), 'h32F);
        @(negedge CLK);
        RSTn = 1'b1;
        repeat (6) @(negedge CLK);
        check("reset_mid_no_done", done_cnt, 0);

        // Entry 0 carries delay 100; gap from its SPI completion to the next request.
        rom[0][25:10] = 16'd100;
        clear_stats();
        pulse_start(2);
        ok = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(posedge CLK);
            if (SPI_Done_Sig) begin
                ok = 1'b1;
                break;
            end
        end
        meas = 0;
        for (int k = 0; k < 1000 && ok; k++) begin
            @(posedge CLK);
            #1;
            meas++;
            if (SPI_Start_Sig) break;
        end
        check("delay_gap", meas, EXP_GAP);
        wait_done();
        check("delay_done_once", done_cnt, 1);
        rom[0][25:10] = 16'd0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
